// File: rtl/screen_pkg.sv
// Shared definitions for the screen-select path: FSM state encoding, default
// screen-index geometry and the per-screen ROM size used by the image loader.
package screen_pkg;

    // Default number of stored screens and index width.
    localparam int DEF_NUM_SCREENS = 8;
    localparam int DEF_SEL_W       = 3;

    // ROM words per stored screen (320x240), shared with imageloader.
    localparam int DEF_SCREEN_WORDS = 76800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_t;

endpackage

// File: rtl/sw_debounce.sv
// Stable-value filter for a switch bus. Any change on the raw bus restarts a
// saturating counter; once the bus has held still long enough, the low KEEP_W
// bits are published as the stable value. The remaining bits only take part
// in change detection.
module sw_debounce #(
    parameter int WIDTH        = 8,
    parameter int KEEP_W       = WIDTH,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  raw,
    output logic [KEEP_W-1:0] stable
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] raw_q;
    logic [CNT_W-1:0] cnt;

    // Restart on change, count while still, latch once the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q  <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= raw_q[KEEP_W-1:0];
            end
        end
    end

endmodule

// File: rtl/screen_sel_ctrl.sv
// Display-screen controller for the VGA path. Screen requests arrive from the
// POS logic (valid/ready) or from debounced board switches (sw[7] = manual
// mode, sw[SEL_W-1:0] = index). A new screen is committed only on the vsync
// falling edge so that no frame tears.
// Optional build macro SCREEN_BLANK_EN: after each commit the RGB stage is
// forced black for BLANK_FRAMES frames; without it blank_req is tied low.
module screen_sel_ctrl #(
    parameter int NUM_SCREENS  = screen_pkg::DEF_NUM_SCREENS,
    parameter int SEL_W        = screen_pkg::DEF_SEL_W,
    parameter int SCREEN_WORDS = screen_pkg::DEF_SCREEN_WORDS,
    parameter int ADDR_W       = 20,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLANK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic [7:0]        sw,
    input  logic              req_valid,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              req_ready,
    output logic [SEL_W-1:0]  active_sel,
    output logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              blank_req,
    output logic              sel_err
);

    import screen_pkg::*;

    // Mode bit plus index bits are the only switch bits that matter; they are
    // packed at the bottom of the filtered bus, the rest only restart the filter.
    localparam int DEB_W = SEL_W + 1;

    // Full-width multiply, truncated to the address width.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [SEL_W-1:0] idx);
        return ADDR_W'({32'd0, idx} * {{SEL_W{1'b0}}, 32'(SCREEN_WORDS)});
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return {{(32-SEL_W){1'b0}}, idx} < 32'(NUM_SCREENS);
    endfunction

    state_t           state;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] last_man;
    logic [DEB_W-1:0] stable_sw;
    logic             manual_mode;
    logic [SEL_W-1:0] manual_idx;
    logic             prev_vsync;
    logic             frame_edge;
    logic             pos_take;
    logic             man_take;
    logic [SEL_W-1:0] cand;

    sw_debounce #(
        .WIDTH        (8),
        .KEEP_W       (DEB_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sw_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    ({sw[6:SEL_W], sw[7], sw[SEL_W-1:0]}),
        .stable (stable_sw)
    );

    assign manual_mode = stable_sw[SEL_W];
    assign manual_idx  = stable_sw[SEL_W-1:0];

    // One-cycle history of vsync; reset high so release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vsync <= 1'b1;
        end else begin
            prev_vsync <= vsync;
        end
    end

    assign frame_edge = prev_vsync & ~vsync;

    // Pick this cycle's candidate in IDLE: POS first, manual only when POS is quiet.
    always_comb begin
        pos_take = 1'b0;
        man_take = 1'b0;
        cand     = req_sel;
        if (state == IDLE) begin
            if (req_valid) begin
                pos_take = req_ready;
            end else if (manual_mode && (manual_idx != last_man)) begin
                man_take = 1'b1;
                cand     = manual_idx;
            end
        end
    end

`ifdef SCREEN_BLANK_EN
    localparam int FC_W = $clog2(BLANK_FRAMES + 1);
    logic [FC_W-1:0] frame_cnt;
`else
    assign blank_req = 1'b0;
`endif

    // Switch FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            last_man   <= '0;
            active_sel <= '0;
            base_addr  <= '0;
            busy       <= 1'b0;
            sel_err    <= 1'b0;
            req_ready  <= 1'b0;
`ifdef SCREEN_BLANK_EN
            blank_req  <= 1'b0;
            frame_cnt  <= '0;
`endif
        end else begin
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (pos_take || man_take) begin
                        // The manual index is consumed even when it is rejected.
                        if (man_take) begin
                            last_man <= cand;
                        end
                        if (!in_range(cand)) begin
                            sel_err <= 1'b1;
                        end else if (cand != active_sel) begin
                            target    <= cand;
                            state     <= PENDING;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end

                PENDING: begin
                    if (frame_edge) begin
                        active_sel <= target;
                        base_addr  <= addr_of(target);
`ifdef SCREEN_BLANK_EN
                        state      <= BLANK;
                        blank_req  <= 1'b1;
                        frame_cnt  <= '0;
`else
                        state      <= IDLE;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
`endif
                    end
                end

`ifdef SCREEN_BLANK_EN
                BLANK: begin
                    if (frame_edge) begin
                        if (frame_cnt == FC_W'(BLANK_FRAMES - 1)) begin
                            state     <= IDLE;
                            blank_req <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                        end
                    end
                end
`endif

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_sel_ctrl.sv
// Bench for screen_sel_ctrl: directed scenarios plus a randomized run, all
// checked against a frame/handshake-level reference model held in the bench.
module tb_screen_sel_ctrl;

    localparam int NS    = 7;
    localparam int SW_W  = 3;
    localparam int WORDS = 76800;
    localparam int AW    = 20;
    localparam int DEB   = 16;
    localparam int BF    = 2;
`ifdef SCREEN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            vsync;
    logic [7:0]      sw;
    logic            req_valid;
    logic [SW_W-1:0] req_sel;
    logic            req_ready;
    logic [SW_W-1:0] active_sel;
    logic [AW-1:0]   base_addr;
    logic            busy;
    logic            blank_req;
    logic            sel_err;

    int checks = 0;
    int errors = 0;

    screen_sel_ctrl #(
        .NUM_SCREENS  (NS),
        .SEL_W        (SW_W),
        .SCREEN_WORDS (WORDS),
        .ADDR_W       (AW),
        .DEBOUNCE_CYC (DEB),
        .BLANK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .sw         (sw),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .active_sel (active_sel),
        .base_addr  (base_addr),
        .busy       (busy),
        .blank_req  (blank_req),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a switch is "pending" until a frame edge, then leaves
    // a number of black frames still owed; the switch filter is a run length.
    bit         m_prev_vs;
    logic [7:0] m_sw_last;
    int         m_run;
    logic [7:0] m_stable;
    bit         m_pending;
    int         m_blank_left;
    int         m_active;
    int         m_target;
    int         m_last_man;
    bit         m_err;
    bit         m_ready;

    task automatic model_reset();
        m_prev_vs = 1'b1; m_sw_last = 8'h00; m_run = 1; m_stable = 8'h00;
        m_pending = 1'b0; m_blank_left = 0; m_active = 0; m_target = 0;
        m_last_man = 0; m_err = 1'b0; m_ready = 1'b0;
    endtask

    task automatic model_step();
        bit fe, idle, take, man;
        int cand;
        logic [7:0] n_stable;
        fe = m_prev_vs && !vsync;
        idle = !m_pending && (m_blank_left == 0);
        take = 1'b0; man = 1'b0; cand = 0;
        m_err = 1'b0;
        if (idle) begin
            if (req_valid) begin
                if (m_ready) begin take = 1'b1; cand = int'(req_sel); end
            end else if (m_stable[7] && (int'(m_stable[2:0]) != m_last_man)) begin
                take = 1'b1; man = 1'b1; cand = int'(m_stable[2:0]);
            end
        end
        if (take) begin
            if (man) m_last_man = cand;
            if (cand >= NS) m_err = 1'b1;
            else if (cand != m_active) begin m_target = cand; m_pending = 1'b1; end
        end else if (m_pending && fe) begin
            m_active = m_target; m_pending = 1'b0; m_blank_left = BLANK_ON ? BF : 0;
        end else if (m_blank_left > 0 && fe) begin
            m_blank_left = m_blank_left - 1;
        end
        if (sw === m_sw_last) begin
            if (m_run < DEB + 1) m_run++;
        end else begin
            m_run = 1;
        end
        m_sw_last = sw;
        n_stable = (m_run >= DEB + 1) ? sw : m_stable;
        m_stable = n_stable;
        m_prev_vs = vsync;
        m_ready = !m_pending && (m_blank_left == 0);
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        vsync = 1'b0; tick();
        vsync = 1'b1; tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 12) begin frame_pulse(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b after %0d frames, required 0", busy, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b1; sw = 8'h00; req_valid = 1'b0; req_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (active_sel !== 3'd0) begin errors++; $display("FAIL rst_active: got %0d required 0", active_sel); end
        checks++; if (base_addr !== 20'd0) begin errors++; $display("FAIL rst_base: got %0d required 0", base_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        checks++; if (blank_req !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL rst_flags: blank=%b err=%b required 0 0", blank_req, sel_err); end
        rst_n = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
        // Start a switch, then reset while it is pending.
        req_valid = 1'b1; req_sel = 3'd3;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b required 1", busy); end
        tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: busy=%b ready=%b required 0 0", busy, req_ready); end
        checks++; if (active_sel !== 3'd0 || base_addr !== 20'd0) begin errors++; $display("FAIL rst_mid_data: sel=%0d base=%0d required 0 0", active_sel, base_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready: got %b required 1", req_ready); end
        frame_pulse();
        checks++; if (active_sel !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_target_lost: sel=%0d busy=%b required 0 0", active_sel, busy); end
    endtask

    task automatic test_pos_request();
        wait_idle();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pos_ready: got %b required 1", req_ready); end
        req_valid = 1'b1; req_sel = 3'd3;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL pos_accept: busy=%b ready=%b required 1 0", busy, req_ready); end
        repeat (5) tick();
        checks++; if (active_sel !== 3'd0) begin errors++; $display("FAIL pos_wait_frame: got %0d required 0", active_sel); end
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        checks++; if (active_sel !== 3'd3) begin errors++; $display("FAIL pos_commit_sel: got %0d required 3", active_sel); end
        checks++; if (base_addr !== 20'd230400) begin errors++; $display("FAIL pos_commit_base: got %0d required 230400", base_addr); end
        if (BLANK_ON) begin
            checks++; if (blank_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pos_blank_start: blank=%b busy=%b required 1 1", blank_req, busy); end
            for (int f = 0; f < BF; f++) begin
                repeat (6) tick();
                checks++; if (blank_req !== 1'b1) begin errors++; $display("FAIL pos_blank_hold: got %b required 1 in frame %0d", blank_req, f); end
                vsync = 1'b0; tick(); vsync = 1'b1;
            end
            checks++; if (blank_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL pos_blank_end: blank=%b busy=%b ready=%b required 0 0 1", blank_req, busy, req_ready); end
        end else begin
            checks++; if (blank_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL pos_done: blank=%b busy=%b ready=%b required 0 0 1", blank_req, busy, req_ready); end
        end
        tick();
    endtask

    task automatic test_debounce();
        int n;
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            sw = (i % 2 == 0) ? 8'h85 : 8'h05;
            for (int k = 0; k < 10; k++) begin
                vsync = ($urandom_range(0, 5) != 0);
                tick();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deb_bounce_busy: got %b required 0", busy); end
            end
        end
        vsync = 1'b1;
        sw = 8'h85;
        n = 0;
        while (busy !== 1'b1 && n < 3 * DEB) begin tick(); n++; end
        checks++; if (n != DEB + 2) begin errors++; $display("FAIL deb_latency: busy after %0d cycles, required %0d", n, DEB + 2); end
        frame_pulse();
        checks++; if (active_sel !== 3'd5 || base_addr !== 20'd384000) begin errors++; $display("FAIL deb_commit: sel=%0d base=%0d required 5 384000", active_sel, base_addr); end
        wait_idle();
        sw = 8'h03;
        for (int k = 0; k < 2 * DEB + 4; k++) begin
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deb_manual_off: busy=%b required 0", busy); end
        end
        checks++; if (active_sel !== 3'd5) begin errors++; $display("FAIL deb_manual_off_sel: got %0d required 5", active_sel); end
    endtask

    task automatic test_priority();
        int n = 0;
        wait_idle();
        sw = 8'h86;
        while (m_stable !== 8'h86 && n < 3 * DEB) begin tick(); n++; end
        req_valid = 1'b1; req_sel = 3'd2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b required 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b required 1", busy); end
        frame_pulse();
        checks++; if (active_sel !== 3'd2) begin errors++; $display("FAIL prio_first: got %0d required 2", active_sel); end
        n = 0;
        while (active_sel !== 3'd6 && n < 8) begin frame_pulse(); n++; end
        checks++; if (active_sel !== 3'd6 || base_addr !== 20'd460800) begin errors++; $display("FAIL prio_second: sel=%0d base=%0d required 6 460800", active_sel, base_addr); end
        wait_idle();
    endtask

    task automatic test_error_noop();
        int pulses = 0;
        wait_idle();
        req_valid = 1'b1; req_sel = 3'd6;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || sel_err !== 1'b0) begin errors++; $display("FAIL noop_same: busy=%b ready=%b err=%b required 0 1 0", busy, req_ready, sel_err); end
        req_valid = 1'b1; req_sel = 3'd7;
        tick();
        req_valid = 1'b0;
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_pos_pulse: got %b required 1", sel_err); end
        checks++; if (busy !== 1'b0 || active_sel !== 3'd6) begin errors++; $display("FAIL err_pos_state: busy=%b sel=%0d required 0 6", busy, active_sel); end
        tick();
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL err_pos_once: got %b required 0", sel_err); end
        sw = 8'h87;
        for (int k = 0; k < 3 * DEB; k++) begin
            tick();
            if (sel_err === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL err_manual_pulses: got %0d required 1", pulses); end
        checks++; if (active_sel !== 3'd6 || busy !== 1'b0) begin errors++; $display("FAIL err_manual_state: sel=%0d busy=%b required 6 0", active_sel, busy); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        bit hs_now;
        wait_idle();
        req_valid = 1'b1; req_sel = 3'd4;
        tick();
        req_sel = 3'd1;
        for (int c = 0; c < 80; c++) begin
            vsync = (c % 8 == 7) ? 1'b0 : 1'b1;
            hs_now = req_valid && req_ready;
            if (hs_now) hs++;
            tick();
            if (hs_now) req_valid = 1'b0;
            checks++; if (busy === 1'b1 && req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_while_busy: ready=%b required 0", req_ready); end
        end
        vsync = 1'b1;
        checks++; if (hs != 1) begin errors++; $display("FAIL bp_handshakes: got %0d required 1", hs); end
        checks++; if (active_sel !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL bp_final: sel=%0d busy=%b required 1 0", active_sel, busy); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                sw = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
                hold = $urandom_range(3, 40);
            end else begin
                hold--;
            end
            req_valid = ($urandom_range(0, 4) == 0);
            req_sel = 3'($urandom_range(0, 7));
            vsync = ($urandom_range(0, 9) != 0);
            tick();
            checks++; if (active_sel !== 3'(m_active)) begin errors++; $display("FAIL rnd_sel @%0d: got %0d required %0d", c, active_sel, m_active); end
            checks++; if (base_addr !== 20'(m_active * WORDS)) begin errors++; $display("FAIL rnd_base @%0d: got %0d required %0d", c, base_addr, m_active * WORDS); end
            checks++; if (busy !== (m_pending || m_blank_left > 0)) begin errors++; $display("FAIL rnd_busy @%0d: got %b required %b", c, busy, (m_pending || m_blank_left > 0)); end
            checks++; if (blank_req !== (m_blank_left > 0)) begin errors++; $display("FAIL rnd_blank @%0d: got %b required %b", c, blank_req, (m_blank_left > 0)); end
            checks++; if (req_ready !== m_ready) begin errors++; $display("FAIL rnd_ready @%0d: got %b required %b", c, req_ready, m_ready); end
            checks++; if (sel_err !== m_err) begin errors++; $display("FAIL rnd_err @%0d: got %b required %b", c, sel_err, m_err); end
        end
        req_valid = 1'b0;
        vsync = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b1; sw = 8'h00; req_valid = 1'b0; req_sel = '0;
        test_reset();
        test_pos_request();
        test_debounce();
        test_priority();
        test_error_noop();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/screen_sel_ctrl.md
Name: screen_sel_ctrl

Overview:
Display-screen controller for the VGA path. It picks which stored screen image the image loader shows. Screen requests come from two sources: the POS logic, over a valid/ready handshake, and the board switches, after debouncing. A new screen is committed only at a frame boundary (vsync falling edge), so no frame tears. The block outputs the active screen index and the image-ROM base address to the image loader, plus a blank request to the RGB output stage.

Parameters:
NUM_SCREENS, 8, number of stored screens; valid indices are 0..NUM_SCREENS-1
SEL_W, 3, screen index width
SCREEN_WORDS, 76800, ROM words per screen (320x240)
ADDR_W, 20, base address width
DEBOUNCE_CYC, 500000, clk cycles a switch value must stay stable before it is accepted
BLANK_FRAMES, 2, frames forced black on each switch (used only with the optional feature)

Ports:
clk  in  1  system clock, same domain as vgasync
rst_n  in  1  asynchronous active-low reset
vsync  in  1  active-low vsync from vgasync, same clock domain
sw  in  8  raw switches; sw[7]=manual mode, sw[SEL_W-1:0]=manual screen index
req_valid  in  1  POS screen request valid
req_sel  in  SEL_W  POS requested screen index
req_ready  out  1  request accepted when req_valid && req_ready
active_sel  out  SEL_W  screen currently displayed
base_addr  out  ADDR_W  active_sel*SCREEN_WORDS
busy  out  1  a switch is pending or in progress
blank_req  out  1  force RGB output to zero
sel_err  out  1  one-cycle pulse when an out-of-range index is accepted or debounced

Behaviour:
- Reset values: active_sel=0, base_addr=0, busy=0, blank_req=0, sel_err=0, req_ready=0, FSM=IDLE.
- Debounce counter cleared; stable switch register = 0.
- Debounce:
  - A counter restarts on any change of raw sw.
  - When the counter reaches DEBOUNCE_CYC-1 with sw unchanged, stable_sw <= sw.
  - Counter saturates; it does not wrap.
- Frame edge: vsync is registered once. frame_edge = prev_vsync & ~vsync, one cycle.
- FSM states: IDLE, PENDING, BLANK.
- IDLE:
  - req_ready=1.
  - POS has priority. When req_valid is high, the request is accepted this cycle.
  - Manual source applies only when there is no POS request: stable_sw[7]=1 and stable_sw[SEL_W-1:0] differs from the last applied manual index.
  - The last applied manual index updates when its candidate is taken, including the out-of-range case.
  - Out-of-range candidate: dropped, sel_err pulses the next cycle, state stays IDLE.
  - Candidate equal to active_sel: no transition.
  - Otherwise: target <= candidate, go to PENDING, busy=1.
- PENDING:
  - req_ready=0; switch changes are only tracked, not acted on.
  - On frame_edge: active_sel <= target and base_addr <= target*SCREEN_WORDS in the same cycle, one cycle after frame_edge goes high.
  - Then go to BLANK if the feature is enabled, else to IDLE.
  - The multiply is done at full width, then truncated to ADDR_W.
- BLANK:
  - blank_req=1; a frame counter counts frame_edge pulses.
  - After BLANK_FRAMES edges, go to IDLE; blank_req falls in that cycle.
- busy=1 in PENDING and BLANK.
- Simultaneous events:
  - POS request and manual change in the same IDLE cycle: POS wins. The manual change is re-evaluated on the next return to IDLE.
  - frame_edge in the same cycle as entering PENDING: not used; the commit waits for the next edge.
- Reset mid-operation: immediate return to the reset values. A pending target is lost.

Optional Feature:
SCREEN_BLANK_EN
- Defined: the BLANK state exists and blank_req behaves as described above.
- Undefined: the BLANK state, frame counter and BLANK_FRAMES logic are removed. PENDING goes directly to IDLE after the commit, and blank_req is tied to 0.

Decomposition:
- Package screen_pkg holds:
  - state enum {IDLE, PENDING, BLANK};
  - SEL_W and NUM_SCREENS defaults;
  - the SCREEN_WORDS constant shared with imageloader.
- One sub-module, sw_debounce: per-bus stable-value filter, parameterised by width and DEBOUNCE_CYC.

Test Plan:
- Reset: hold rst_n low mid-PENDING -> active_sel=0, base_addr=0, busy=0, req_ready=0; after release req_ready=1 in IDLE.
- POS request: req_sel=3 in IDLE -> accepted that cycle, busy=1; at the next frame_edge+1 cycle active_sel=3, base_addr=230400. With SCREEN_BLANK_EN, blank_req=1 for exactly 2 frames.
- Debounce:
  - sw=8'h85 bouncing every 1000 cycles, then stable -> no action until stable for 500000 cycles; then target=5, committed at the next frame edge.
  - sw[7]=0 -> ignored.
- Priority: req_valid with req_sel=2 in the same cycle stable_sw produces index 6 -> screen 2 committed first, then screen 6 after it returns to IDLE.
- Error and no-op: req_sel=0 when active_sel=0 -> accepted, no PENDING. With NUM_SCREENS=6 and req_sel=7 -> sel_err pulses once, active_sel unchanged.
- Backpressure: req_valid held during PENDING -> req_ready=0 until IDLE, then accepted exactly once.
